// File: rtl/siphash_pkg.sv
// siphash_pkg: shared types, sizes and helpers
// for the SipHash message feeder.
package siphash_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 8;
  localparam int IDX_W      = $clog2(WORD_BYTES);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_COLLECT,
    ST_COMP,
    ST_GUARD,
    ST_WAIT,
    ST_CLEAR,
    ST_PAD,
    ST_FCOMP,
    ST_FIN,
    ST_RESP
  } feeder_state_e;

  // Final block: zero-padded tail bytes with
  // the message length in the top byte.
  function automatic logic [BYTE_W*WORD_BYTES-1:0] mk_final_block(
    input logic [BYTE_W*WORD_BYTES-1:0] blk,
    input logic [BYTE_W-1:0]            len
  );
    mk_final_block = {len, blk[BYTE_W*(WORD_BYTES-1)-1:0]};
  endfunction

endpackage

// File: rtl/siphash_byte_packer.sv
// siphash_byte_packer: little-endian byte buffer
// with index, length and last-byte tracking.
module siphash_byte_packer
  import siphash_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         init_i,
  input  logic                         wr_i,
  input  logic [BYTE_W-1:0]            data_i,
  input  logic                         last_i,
  input  logic                         clr_i,
  input  logic                         pad_i,
  output logic [BYTE_W*WORD_BYTES-1:0] blk_o,
  output logic                         full_o,
  output logic                         last_o
);

  logic [BYTE_W*WORD_BYTES-1:0] blk_q, blk_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [BYTE_W-1:0]            len_q, len_d;
  logic                         last_q, last_d;

  // Buffer and counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      blk_q  <= '0;
      idx_q  <= '0;
      len_q  <= '0;
      last_q <= 1'b0;
    end else begin
      blk_q  <= blk_d;
      idx_q  <= idx_d;
      len_q  <= len_d;
      last_q <= last_d;
    end
  end

  // Byte insert, block clear and length padding.
  always_comb begin
    blk_d  = blk_q;
    idx_d  = idx_q;
    len_d  = len_q;
    last_d = last_q;
    if (init_i) begin
      blk_d  = '0;
      idx_d  = '0;
      len_d  = '0;
      last_d = 1'b0;
    end else if (wr_i) begin
      blk_d[BYTE_W*idx_q +: BYTE_W] = data_i;
      idx_d  = idx_q + 1'b1;
      len_d  = len_q + 1'b1;
      last_d = last_i;
    end else if (clr_i) begin
      blk_d = '0;
      idx_d = '0;
    end else if (pad_i) begin
      blk_d = mk_final_block(blk_q, len_q);
    end
  end

  assign blk_o  = blk_q;
  assign full_o = (idx_q == IDX_W'(WORD_BYTES - 1));
  assign last_o = last_q;

endmodule

// File: rtl/siphash_msg_feeder.sv
// siphash_msg_feeder: packs a byte stream into
// SipHash blocks and sequences siphash_core.
module siphash_msg_feeder
  import siphash_pkg::*;
#(
  parameter int C_ROUNDS = 2,
  parameter int D_ROUNDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         start_empty,
  input  logic [127:0] key_in,
  input  logic         long_in,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic         core_initalize,
  output logic         core_compress,
  output logic         core_finalize,
  output logic         core_long,
  output logic [127:0] core_key,
  output logic [3:0]   core_compression_rounds,
  output logic [3:0]   core_final_rounds,
  output logic [63:0]  core_mi,
  input  logic         core_ready,
  input  logic [63:0]  core_word,
  input  logic         core_word_valid,
  output logic         core_resp_rec,
  output logic [63:0]  digest,
  output logic         digest_valid,
  output logic         busy
);

  feeder_state_e state_q, state_d;
  feeder_state_e ret_q, ret_d;

  logic [127:0] key_q, key_d;
  logic         long_q, long_d;
  logic         empty_q, empty_d;
  logic         srdy_q, srdy_d;
  logic [63:0]  digest_q, digest_d;
  logic         dvalid_q, resp_q;

  logic pk_init, pk_wr, pk_clr, pk_pad;
  logic pk_full, pk_last;
  logic cmd_init, cmd_comp, cmd_fin, cap;

  siphash_byte_packer u_packer (
    .clk_i   (clk),
    .reset_i (reset),
    .init_i  (pk_init),
    .wr_i    (pk_wr),
    .data_i  (s_data),
    .last_i  (s_last),
    .clr_i   (pk_clr),
    .pad_i   (pk_pad),
    .blk_o   (core_mi),
    .full_o  (pk_full),
    .last_o  (pk_last)
  );

  // State, latched request and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ret_q    <= ST_IDLE;
      key_q    <= '0;
      long_q   <= 1'b0;
      empty_q  <= 1'b0;
      srdy_q   <= 1'b0;
      digest_q <= '0;
      dvalid_q <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      key_q    <= key_d;
      long_q   <= long_d;
      empty_q  <= empty_d;
      srdy_q   <= srdy_d;
      digest_q <= digest_d;
      dvalid_q <= cap;
      resp_q   <= cap;
    end
  end

  // Next state, packer controls and core commands.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    key_d    = key_q;
    long_d   = long_q;
    empty_d  = empty_q;
    digest_d = digest_q;
    pk_init  = 1'b0;
    pk_wr    = 1'b0;
    pk_clr   = 1'b0;
    pk_pad   = 1'b0;
    cmd_init = 1'b0;
    cmd_comp = 1'b0;
    cmd_fin  = 1'b0;
    cap      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          long_d  = long_in;
          empty_d = start_empty;
          pk_init = 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        if (core_ready) begin
          cmd_init = 1'b1;
          ret_d    = empty_q ? ST_PAD : ST_COLLECT;
          state_d  = ST_GUARD;
        end
      end
      ST_COLLECT: begin
        if (s_valid && srdy_q) begin
          pk_wr = 1'b1;
          if (pk_full) begin
            state_d = ST_COMP;
          end else if (s_last) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_COMP: begin
        if (core_ready) begin
          cmd_comp = 1'b1;
          ret_d    = ST_CLEAR;
          state_d  = ST_GUARD;
        end
      end
      ST_GUARD: begin
        state_d = (ret_q == ST_RESP) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (core_ready) begin
          state_d = ret_q;
        end
      end
      ST_CLEAR: begin
        pk_clr  = 1'b1;
        state_d = pk_last ? ST_PAD : ST_COLLECT;
      end
      ST_PAD: begin
        pk_pad  = 1'b1;
        state_d = ST_FCOMP;
      end
      ST_FCOMP: begin
        if (core_ready) begin
          cmd_comp = 1'b1;
          ret_d    = ST_FIN;
          state_d  = ST_GUARD;
        end
      end
      ST_FIN: begin
        if (core_ready) begin
          cmd_fin = 1'b1;
          ret_d   = ST_RESP;
          state_d = ST_GUARD;
        end
      end
      ST_RESP: begin
        if (core_word_valid) begin
          cap      = 1'b1;
          digest_d = core_word;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    srdy_d = (state_d == ST_COLLECT);
  end

  assign s_ready        = srdy_q;
  assign core_initalize = cmd_init & ~reset;
  assign core_compress  = cmd_comp & ~reset;
  assign core_finalize  = cmd_fin & ~reset;
  assign core_long      = long_q;
  assign core_key       = key_q;
  assign core_resp_rec  = resp_q;
  assign digest         = digest_q;
  assign digest_valid   = dvalid_q;
  assign busy           = (state_q != ST_IDLE);

  assign core_compression_rounds = 4'(C_ROUNDS);
  assign core_final_rounds       = 4'(D_ROUNDS);

endmodule

// File: doc/siphash_msg_feeder.md
# siphash_msg_feeder

Upstream stage of `siphash_core`. It accepts a byte-serial message with a valid/ready handshake and packs it little-endian into 64-bit `mi` words. It sequences the core's initalize → compress* → finalize commands, builds the SipHash final block (length mod 256 in the top byte), and returns the 64-bit tag with a one-cycle `digest_valid` pulse. It also drives the core's `resp_rec` acknowledge.

## Interface
- `C_ROUNDS`, default 2: value driven on `core_compression_rounds`.
- `D_ROUNDS`, default 4: value driven on `core_final_rounds`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: pulse; begins a message; accepted only in IDLE.
- `start_empty` in 1: sampled with `start`; the message has zero bytes.
- `key_in` in 128: latched at `start`; `[63:0]`=k0, `[127:64]`=k1.
- `long_in` in 1: latched at `start`.
- `s_data` in 8: message byte.
- `s_valid` in 1: byte valid.
- `s_last` in 1: qualifies the final byte.
- `s_ready` out 1: byte accepted when `s_valid & s_ready`.
- `core_initalize`, `core_compress`, `core_finalize` out 1 each: one-cycle command pulses.
- `core_long` out 1, `core_key` out 128: latched copies.
- `core_compression_rounds`, `core_final_rounds` out 4: parameters.
- `core_mi` out 64: block, held stable from the compress pulse until the next block load.
- `core_ready` in 1: core can take a command.
- `core_word` in 64, `core_word_valid` in 1: result from the core.
- `core_resp_rec` out 1: one-cycle acknowledge of the result.
- `digest` out 64, `digest_valid` out 1 (pulse).
- `busy` out 1: high in any state except IDLE.

## Operation
- Reset values: all outputs 0 except the constants `core_compression_rounds`=C_ROUNDS and `core_final_rounds`=D_ROUNDS. Buffer, index (3b), length (8b) and last flag are cleared. State is IDLE.
- States and transitions:
  - IDLE: on `start`, latch key, long and empty; clear buffer, index and length; go to INIT. `s_valid` is ignored.
  - INIT: wait for `core_ready`=1, pulse `core_initalize`, go to GUARD. Return target is PAD if empty, otherwise COLLECT.
  - COLLECT: `s_ready`=1. On an accepted byte, write `buf[8*idx+:8]`, increment idx, increment length (mod 256), and record `s_last`.
    - idx was 7: go to COMP.
    - `s_last` with idx<7: go to PAD.
  - COMP: wait for `core_ready`, pulse `core_compress` with `core_mi`=buf, go to GUARD. Return target is CLEAR.
  - GUARD: one cycle with `core_ready` ignored, then WAIT.
  - WAIT: hold until `core_ready`=1, then go to the return target.
  - CLEAR: zero the buffer and idx. Go to PAD if the last flag is set, otherwise COLLECT.
  - PAD: `buf[63:56]`=length. Go to FCOMP, which pulses `core_compress` and goes through GUARD/WAIT to FIN.
  - FIN: pulse `core_finalize`, go to a GUARD cycle, then RESP.
  - RESP: wait for `core_word_valid`=1; capture `core_word` into `digest`; pulse `core_resp_rec` and `digest_valid` in the same cycle; go to IDLE.
- Final block: bytes occupy `[8*idx-1:0]`, zeros follow up to bit 55, and the length byte is at `[63:56]`. idx≤7 always holds here, so data never overlaps the length byte.
- A message of exactly 8k bytes issues k full compresses followed by a final block of `{len,56'h0}`.
- `start` outside IDLE is ignored. `s_last` without `s_valid` is ignored.
- `reset` in any state returns to IDLE on the next edge. No command pulse is issued in the cycle after reset.

## Timing
- At most one byte per cycle. `s_ready` is registered; it drops in the cycle after a block completes.
- A command pulse is issued in the first state cycle where `core_ready`=1, so the minimum is 1 cycle per command state.
- GUARD always inserts exactly one cycle after every command. This hides the combinational `done` glitch of the core.
- `digest` holds its value until the next capture. `digest_valid` is high for exactly 1 cycle.
- Length wraps modulo 256; only the low 8 bits enter the final block.

## Structure
- Package `siphash_pkg`:
  - state enum for the feeder;
  - `BYTE_W`=8, `WORD_BYTES`=8;
  - the `mk_final_block(buf, len)` function.
- Sub-module `siphash_byte_packer`: byte buffer, idx and length counters, and the clear/pad controls. The top level holds the FSM and the core handshake.

## Test plan
All digests are checked against a behavioral SipHash-2-4 model and the real `siphash_core`. Key is `128'h0f0e0d0c0b0a0908_0706050403020100`.
1. Reset mid-COMP → next cycle all command pulses are 0, `busy`=0, `s_ready`=0, `digest_valid`=0.
2. Empty message (`start_empty`=1) → single compress with `core_mi`=`64'h0`, then finalize; `digest`=`64'h726fdb47dd0e0e31`.
3. Bytes 00..07 → compress with `mi`=`64'h0706050403020100`, then `mi`=`64'h0800000000000000`; `digest`=`64'h93f5f5799a932462`.
4. Bytes 00 01 02 with `s_valid` gaps → final `mi`=`64'h0300000000020100`; exactly one `core_resp_rec` pulse.
5. 300-byte message, `core_ready` held low for random stretches → 38 compress pulses; last `mi[63:56]`=`8'h2c`; `s_ready` is 0 whenever the FSM is outside COLLECT.
6. `start` pulsed while `busy` → no effect. A second back-to-back message starting the cycle after `digest_valid` → correct digest.
